// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU decode stage.
//   alu_op_e    3-bit ALU operation code
//   OPC_*       RV32I opcodes this stage decodes
//   alu_ctrl_t  decoded control/operand bundle (also the pipeline register)
// Optional macro used by consumers: ALU_DEC_ILLEGAL_CHECK_EN.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_XOR  = 3'b010,
    ALU_ADD  = 3'b011,
    ALU_SR   = 3'b100,
    ALU_SL   = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

  typedef struct packed {
    alu_op_e           op;
    logic              cin;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [4:0]        rd;
    logic              reg_write;
    logic              illegal;
  } alu_ctrl_t;

  function automatic alu_op_e f3_to_op(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SR;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Comparisons always run the adder in subtract mode; bit 30 picks SUB
  // (register form only) and arithmetic right shift.
  function automatic logic f3_to_cin(input logic [2:0] f3, input logic bit30,
                                     input logic is_reg);
    logic cin;
    case (f3)
      3'b000:         cin = is_reg & bit30;
      3'b010, 3'b011: cin = 1'b1;
      3'b101:         cin = bit30;
      default:        cin = 1'b0;
    endcase
    return cin;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: purely combinational RV32I compute-instruction decoder.
//   instr     in  32      raw instruction word
//   pc        in  DATA_W  instruction PC (AUIPC operand)
//   rs1_data  in  DATA_W  register-file read data
//   rs2_data  in  DATA_W  register-file read data
//   ctrl      out         decoded alu_ctrl_t
// Macro ALU_DEC_ILLEGAL_CHECK_EN: when defined, malformed/unsupported
// encodings are flagged and turned into NOPs; otherwise unsupported opcodes
// become silent NOPs and funct7 bits other than bit 30 are ignored.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output alu_ctrl_t         ctrl
);

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic              is_shift;
  logic [DATA_W-1:0] imm_i;
  logic [DATA_W-1:0] imm_u;

  assign opcode   = instr[6:0];
  assign f3       = instr[14:12];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_u    = {instr[31:12], 12'b0};

`ifdef ALU_DEC_ILLEGAL_CHECK_EN
  logic [6:0] f7;
  logic       enc_ok;
  assign f7 = instr[31:25];

  always_comb begin
    enc_ok = 1'b1;
    case (opcode)
      OPC_OP:
        enc_ok = (f7 == 7'b0000000) ||
                 ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      OPC_OP_IMM: begin
        if (f3 == 3'b001)
          enc_ok = (f7 == 7'b0000000);
        else if (f3 == 3'b101)
          enc_ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
      end
      OPC_LUI, OPC_AUIPC: enc_ok = 1'b1;
      default:            enc_ok = 1'b0;
    endcase
  end
`endif

  always_comb begin
    // Default is the NOP form: ADD 0+0 with no write-back.
    ctrl    = '0;
    ctrl.op = ALU_ADD;
    ctrl.rd = instr[11:7];
    case (opcode)
      OPC_OP: begin
        ctrl.op        = f3_to_op(f3);
        ctrl.cin       = f3_to_cin(f3, instr[30], 1'b1);
        ctrl.a         = rs1_data;
        ctrl.b         = rs2_data;
        ctrl.reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl.op        = f3_to_op(f3);
        ctrl.cin       = f3_to_cin(f3, instr[30], 1'b0);
        ctrl.a         = rs1_data;
        ctrl.b         = is_shift ? {27'b0, instr[24:20]} : imm_i;
        ctrl.reg_write = 1'b1;
      end
      OPC_LUI: begin
        ctrl.b         = imm_u;
        ctrl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.a         = pc;
        ctrl.b         = imm_u;
        ctrl.reg_write = 1'b1;
      end
      default: ;
    endcase
`ifdef ALU_DEC_ILLEGAL_CHECK_EN
    if (!enc_ok) begin
      ctrl.op        = ALU_ADD;
      ctrl.cin       = 1'b0;
      ctrl.a         = '0;
      ctrl.b         = '0;
      ctrl.reg_write = 1'b0;
      ctrl.illegal   = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: one-cycle decode pipeline stage in front of the ALU.
//   clk, rst                      clock, async active-high reset
//   in_valid/in_ready             upstream handshake
//   in_instr, in_pc               instruction word and its PC
//   in_rs1_data, in_rs2_data      register read data
//   flush                         kill registered and incoming instruction
//   out_valid/out_ready           downstream handshake
//   alu_op, alu_cin, alu_a, alu_b ALU controls and operands
//   rd, reg_write, illegal        write-back target, enable, bad encoding
// Macro ALU_DEC_ILLEGAL_CHECK_EN enables illegal-encoding detection in the
// decoder; with it undefined, illegal stays 0.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int XLEN = DATA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      alu_op,
  output logic            alu_cin,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            illegal
);

  alu_ctrl_t dec_ctrl;
  alu_ctrl_t ctrl_q;
  logic      take;

  alu_ctrl_dec u_dec (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .ctrl     (dec_ctrl)
  );

  assign in_ready = !out_valid || out_ready;
  assign take     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (take)      out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      // A flushed transfer is dropped, so the register keeps its stale data.
      if (take && !flush) ctrl_q <= dec_ctrl;
    end
  end

  assign alu_op    = ctrl_q.op;
  assign alu_cin   = ctrl_q.cin;
  assign alu_a     = ctrl_q.a;
  assign alu_b     = ctrl_q.b;
  assign rd        = ctrl_q.rd;
  assign reg_write = ctrl_q.reg_write;
  assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: directed plus random checking of alu_decode_stage
// against a reference model of the instruction-set rules and a queue
// scoreboard of in-flight instructions. Honours ALU_DEC_ILLEGAL_CHECK_EN.
module tb_alu_decode_stage;

`ifdef ALU_DEC_ILLEGAL_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
  logic [2:0]  alu_op;
  logic        alu_cin, reg_write, illegal;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  rd;

  always #5 clk = ~clk;

  alu_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .alu_cin(alu_cin), .alu_a(alu_a), .alu_b(alu_b),
    .rd(rd), .reg_write(reg_write), .illegal(illegal)
  );

  typedef struct {
    logic [2:0]  op;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: ISA-level meaning of each instruction.
  function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t        e;
    logic [2:0]  op_of_f3 [8] = '{3'd3, 3'd5, 3'd7, 3'd6, 3'd2, 3'd4, 3'd1, 3'd0};
    logic [6:0]  opc = ins[6:0];
    int          f3  = int'(ins[14:12]);
    logic [6:0]  f7  = ins[31:25];
    bit          is_op  = (opc == 7'h33);
    bit          is_imm = (opc == 7'h13);
    bit          legal;
    e.op = 3'd3; e.cin = 1'b0; e.a = 0; e.b = 0; e.rd = ins[11:7];
    e.we = 1'b0; e.ill = 1'b0;
    if (is_op)       legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
    else if (is_imm) legal = (f3 == 1) ? (f7 == 0) :
                             (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
    else             legal = (opc == 7'h37) || (opc == 7'h17);
    if (CHK_EN && !legal) begin
      e.ill = 1'b1;
      return e;
    end
    if (is_op || is_imm) begin
      e.op = op_of_f3[f3];
      e.a  = rs1;
      e.we = 1'b1;
      if (f3 == 2 || f3 == 3) e.cin = 1'b1;
      else if (f3 == 5)       e.cin = ins[30];
      else if (f3 == 0)       e.cin = is_op ? ins[30] : 1'b0;
      if (is_op)                  e.b = rs2;
      else if (f3 == 1 || f3 == 5) e.b = 32'(ins[24:20]);
      else                        e.b = 32'($signed(ins[31:20]));
    end else if (opc == 7'h37 || opc == 7'h17) begin
      e.b  = ins & 32'hFFFF_F000;
      e.a  = (opc == 7'h17) ? pc : 32'd0;
      e.we = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r   = $urandom;
    int          sel = $urandom_range(0, 9);
    int          k   = $urandom_range(0, 3);
    if (sel <= 3)      r[6:0] = 7'h33;
    else if (sel <= 6) r[6:0] = 7'h13;
    else if (sel == 7) r[6:0] = 7'h37;
    else if (sel == 8) r[6:0] = 7'h17;
    if (k <= 1)      r[31:25] = 7'h00;
    else if (k == 2) r[31:25] = 7'h20;
    return r;
  endfunction

  task automatic check_out();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("alu_op",    32'(alu_op),    32'(q[0].op));
      chk("alu_cin",   32'(alu_cin),   32'(q[0].cin));
      chk("alu_a",     alu_a,          q[0].a);
      chk("alu_b",     alu_b,          q[0].b);
      chk("rd",        32'(rd),        32'(q[0].rd));
      chk("reg_write", 32'(reg_write), 32'(q[0].we));
      chk("illegal",   32'(illegal),   32'(q[0].ill));
    end
  endtask

  // Called just after a negedge with inputs already driven; returns at the
  // next negedge with the scoreboard advanced and outputs checked.
  task automatic drive_cycle();
    bit   rdy_m, take, fire;
    exp_t e;
    #1;
    rdy_m = (q.size() == 0) || out_ready;
    chk("in_ready", 32'(in_ready), 32'(rdy_m));
    take = in_valid && rdy_m;
    fire = (q.size() != 0) && out_ready;
    e    = ref_model(in_instr, in_pc, in_rs1_data, in_rs2_data);
    @(posedge clk);
    if (fire) void'(q.pop_front());
    if (flush) q.delete();
    else if (take) q.push_back(e);
    #1;
    check_out();
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_op"},    32'(alu_op), 0);
    chk({tag, "_cin"},   32'(alu_cin), 0);
    chk({tag, "_a"},     alu_a, 0);
    chk({tag, "_b"},     alu_b, 0);
    chk({tag, "_rd"},    32'(rd), 0);
    chk({tag, "_we"},    32'(reg_write), 0);
    chk({tag, "_ill"},   32'(illegal), 0);
  endtask

  task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2);
    in_valid = v; in_instr = ins; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    #2;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    set_in(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7);
    drive_cycle();
    chk("add_valid", 32'(out_valid), 1);
    chk("add_op", 32'(alu_op), 3);
    chk("add_cin", 32'(alu_cin), 0);
    chk("add_a", alu_a, 5);
    chk("add_b", alu_b, 7);
    chk("add_rd", 32'(rd), 3);
    chk("add_we", 32'(reg_write), 1);

    set_in(1'b1, 32'h402081B3, 32'h0, 32'd5, 32'd7);
    drive_cycle();
    chk("sub_op", 32'(alu_op), 3);
    chk("sub_cin", 32'(alu_cin), 1);

    set_in(1'b1, 32'h40335293, 32'h0, 32'h8000_0000, 32'h0);
    drive_cycle();
    chk("srai_op", 32'(alu_op), 4);
    chk("srai_cin", 32'(alu_cin), 1);
    chk("srai_b", alu_b, 3);
    chk("srai_rd", 32'(rd), 5);

    set_in(1'b1, 32'h123450B7, 32'h0, 32'h1111, 32'h2222);
    drive_cycle();
    chk("lui_a", alu_a, 0);
    chk("lui_b", alu_b, 32'h12345000);
    chk("lui_op", 32'(alu_op), 3);

    set_in(1'b1, 32'h12345097, 32'h100, 32'h1111, 32'h2222);
    drive_cycle();
    chk("auipc_a", alu_a, 32'h100);
    chk("auipc_b", alu_b, 32'h12345000);

    // Stall: held ADD must survive three cycles of back-pressure.
    set_in(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7);
    drive_cycle();
    out_ready = 1'b0;
    set_in(1'b1, 32'h402081B3, 32'h0, 32'd9, 32'd4);
    for (int i = 0; i < 3; i++) begin
      drive_cycle();
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_b", alu_b, 7);
      chk("stall_cin", 32'(alu_cin), 0);
    end
    out_ready = 1'b1;
    drive_cycle();
    chk("release_valid", 32'(out_valid), 1);
    chk("release_cin", 32'(alu_cin), 1);
    chk("release_a", alu_a, 9);

    flush = 1'b1;
    set_in(1'b1, 32'h002081B3, 32'h0, 32'd1, 32'd2);
    drive_cycle();
    chk("flush_valid", 32'(out_valid), 0);
    flush = 1'b0;

    set_in(1'b1, 32'hFE2081B3, 32'h0, 32'd5, 32'd7);
    drive_cycle();
    chk("fe_illegal", 32'(illegal), 32'(CHK_EN));
    chk("fe_we", 32'(reg_write), 32'(!CHK_EN));

    // Asynchronous reset while an instruction is held.
    set_in(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7);
    drive_cycle();
    out_ready = 1'b0;
    drive_cycle();
    chk("held_valid", 32'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      set_in($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      drive_cycle();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, bad=%0d", n_bad);
    $fatal(1);
  end

endmodule
